mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- N-channel round-robin arbiter that merges the memory-side ports of several caches onto one external memory bus.
- Generalises the current fixed arrangement of separate instruction and data buses to a parametrised channel count.
- Adds split read/write data, per-channel grant counters and a busy-cycle counter for performance monitoring.
- Sits between the cache instances and the top-level memory interface.

Parameters:
- NCH, 2, number of cache channels (2..8); channel 0 has the highest priority at reset.
- ADDR_WIDTH, 32, memory address width.
- LINE_WIDTH, 256, width of a cache line transfer.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- creq  in  NCH  per-channel request; held high until that channel's cack_n pulse
- cwrite  in  NCH  per-channel write flag (1 = write line, 0 = read line)
- caddr  in  NCH*ADDR_WIDTH  channel i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- cwdata  in  NCH*LINE_WIDTH  channel i write line at [i*LINE_WIDTH +: LINE_WIDTH]
- cack_n  out  NCH  per-channel completion, active-low, one-cycle pulse
- crdata  out  LINE_WIDTH  read line broadcast to all channels; valid while cack_n[g] is low
- mreq  out  1  memory request
- mwrite  out  1  memory write flag
- maddr  out  ADDR_WIDTH  memory address
- mwdata  out  LINE_WIDTH  memory write line
- mack_n  in  1  memory acknowledge, active-low
- mrdata  in  LINE_WIDTH  memory read line; sampled when mack_n is low
- grant_count  out  NCH*CNT_WIDTH  completed transactions per channel
- busy_count  out  CNT_WIDTH  cycles with mreq high

Behaviour:
- Reset values (rst high, async):
  - state IDLE; mreq 0, mwrite 0; maddr and mwdata 0.
  - cack_n all 1; crdata 0.
  - Round-robin pointer last = NCH-1, so channel 0 wins first.
  - All counters 0.
- States are IDLE, BUSY and DONE. All outputs are registered.
- IDLE:
  - If any creq bit is high, select g = first set bit searching last+1, last+2, … with wrap modulo NCH.
  - On the clock edge: latch g; drive mreq=1, mwrite=cwrite[g], maddr=caddr[g], mwdata=cwdata[g]; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mreq, mwrite, maddr and mwdata stay constant, independent of later changes to the channel inputs.
  - When mack_n=0 is sampled:
    - mreq←0, mwrite←0, cack_n[g]←0.
    - crdata←mrdata on a read; crdata holds its previous value on a write.
    - grant_count[g]++, last←g, go to DONE.
- DONE:
  - cack_n←all 1; go to IDLE.
  - creq is not evaluated in DONE. The requester drops creq on the edge after it sees cack_n low, so no stale regrant occurs.
- Latency: creq rises in cycle 0 → mreq=1 in cycle 1. mack_n low in cycle k → cack_n low in cycle k+1. Earliest next grant (mreq=1 again) is cycle k+3.
- busy_count increments in every cycle in which mreq=1.
- All counters wrap modulo 2^CNT_WIDTH with no saturation.
- Simultaneous requests: exactly one grant per transaction. Priority rotates so the most recently served channel has the lowest priority. Starvation is bounded by NCH-1 transactions.
- creq dropped during BUSY: the transaction still completes and cack_n[g] still pulses.
- A new creq on another channel during BUSY or DONE waits; it is considered in the next IDLE cycle.
- mack_n low in IDLE or DONE is ignored.
- rst during BUSY: mreq drops immediately (asynchronously), the transaction is abandoned, no cack_n pulse is issued, and the counters clear.
- NCH=1 degenerates to a pass-through with the same IDLE/BUSY/DONE timing.

Test Plan:
- Single read: NCH=2, creq=01, caddr0=0x1000, memory acks 3 cycles after mreq with mrdata=0xA5…A5 → maddr=0x1000, mwrite=0, cack_n=10 for exactly one cycle, crdata=0xA5…A5, grant_count0=1, busy_count=4.
- Contention: creq=11 from reset, every requester re-requests immediately after each ack, 4 transactions → grant order 0,1,0,1, grant_count0=2, grant_count1=2.
- Write: channel 1 with cwrite=1, caddr=0x2040, cwdata=0x55…55 → mwrite=1, maddr=0x2040, mwdata=0x55…55; crdata unchanged.
- Input stability: change caddr0 and drop creq0 during BUSY → maddr holds the original value; cack_n[0] still pulses once.
- Reset mid-operation: assert rst 2 cycles into BUSY → mreq=0 in the same cycle, no cack_n pulse, counters 0; the next request is granted to channel 0 first.
- Wrap and rotation: NCH=4, CNT_WIDTH=4, 16 grants on channel 3 → grant_count3=0; then creq=1111 → order 0,1,2,3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging NCH cache memory ports onto one external memory bus,
// with split read/write lines, per-channel grant counters and a busy-cycle counter.
module mem_port_arbiter #(
   parameter int unsigned NCH        = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NCH-1:0]            creq,
   input  logic [NCH-1:0]            cwrite,
   input  logic [NCH*ADDR_WIDTH-1:0] caddr,
   input  logic [NCH*LINE_WIDTH-1:0] cwdata,
   output logic [NCH-1:0]            cack_n,
   output logic [LINE_WIDTH-1:0]     crdata,
   output logic                      mreq,
   output logic                      mwrite,
   output logic [ADDR_WIDTH-1:0]     maddr,
   output logic [LINE_WIDTH-1:0]     mwdata,
   input  logic                      mack_n,
   input  logic [LINE_WIDTH-1:0]     mrdata,
   output logic [NCH*CNT_WIDTH-1:0]  grant_count,
   output logic [CNT_WIDTH-1:0]      busy_count
);

   localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state;
   logic [PW-1:0]         last;
   logic [PW-1:0]         gsel;
   logic [PW-1:0]         pick_c;
   logic                  any_c;
   logic [ADDR_WIDTH-1:0] caddr_a  [NCH];
   logic [LINE_WIDTH-1:0] cwdata_a [NCH];
   logic [CNT_WIDTH-1:0]  gcnt     [NCH];

   for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
      assign caddr_a[i]  = caddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign cwdata_a[i] = cwdata[i*LINE_WIDTH +: LINE_WIDTH];
      assign grant_count[i*CNT_WIDTH +: CNT_WIDTH] = gcnt[i];
   end

   // First requester after the last served channel, wrapping modulo NCH.
   always_comb begin
      int idx;
      idx    = 0;
      pick_c = '0;
      any_c  = 1'b0;
      for (int off = 1; off <= int'(NCH); off++) begin
         idx = int'(last) + off;
         if (idx >= int'(NCH)) idx = idx - int'(NCH);
         if (!any_c && creq[PW'(idx)]) begin
            any_c  = 1'b1;
            pick_c = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mreq       <= 1'b0;
         mwrite     <= 1'b0;
         maddr      <= '0;
         mwdata     <= '0;
         cack_n     <= '1;
         crdata     <= '0;
         last       <= PW'(NCH - 1);
         gsel       <= '0;
         busy_count <= '0;
         for (int i = 0; i < int'(NCH); i++) gcnt[i] <= '0;
      end else begin
         if (mreq) busy_count <= busy_count + CNT_WIDTH'(1);
         case (state)
            IDLE: begin
               if (any_c) begin
                  gsel   <= pick_c;
                  mreq   <= 1'b1;
                  mwrite <= cwrite[pick_c];
                  maddr  <= caddr_a[pick_c];
                  mwdata <= cwdata_a[pick_c];
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (!mack_n) begin
                  mreq         <= 1'b0;
                  mwrite       <= 1'b0;
                  cack_n[gsel] <= 1'b0;
                  // mwrite still holds the latched flag of this transaction here.
                  if (!mwrite) crdata <= mrdata;
                  gcnt[gsel]   <= gcnt[gsel] + CNT_WIDTH'(1);
                  last         <= gsel;
                  state        <= DONE;
               end
            end
            DONE: begin
               cack_n <= '1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: a 2-channel instance with
// 32-bit counters and a 4-channel instance with 4-bit counters for wrap/rotation.
module tb_mem_port_arbiter;

   logic clk;
   int   compared;
   int   mismatched;

   // 2-channel instance
   logic          rst2;
   logic [1:0]    creq2, cwrite2, cack_n2;
   logic [63:0]   caddr2;
   logic [511:0]  cwdata2;
   logic [255:0]  crdata2, mwdata2, mrdata2;
   logic          mreq2, mwrite2, mack_n2;
   logic [31:0]   maddr2, busy2;
   logic [63:0]   gc2;

   // 4-channel instance, 4-bit counters
   logic          rst4;
   logic [3:0]    creq4, cwrite4, cack_n4;
   logic [127:0]  caddr4;
   logic [1023:0] cwdata4;
   logic [255:0]  crdata4, mwdata4, mrdata4;
   logic          mreq4, mwrite4, mack_n4;
   logic [31:0]   maddr4;
   logic [3:0]    busy4;
   logic [15:0]   gc4;

   int gch;

   mem_port_arbiter #(.NCH(2), .ADDR_WIDTH(32), .LINE_WIDTH(256), .CNT_WIDTH(32)) dut2 (
      .clk(clk), .rst(rst2), .creq(creq2), .cwrite(cwrite2), .caddr(caddr2),
      .cwdata(cwdata2), .cack_n(cack_n2), .crdata(crdata2), .mreq(mreq2),
      .mwrite(mwrite2), .maddr(maddr2), .mwdata(mwdata2), .mack_n(mack_n2),
      .mrdata(mrdata2), .grant_count(gc2), .busy_count(busy2)
   );

   mem_port_arbiter #(.NCH(4), .ADDR_WIDTH(32), .LINE_WIDTH(256), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .creq(creq4), .cwrite(cwrite4), .caddr(caddr4),
      .cwdata(cwdata4), .cack_n(cack_n4), .crdata(crdata4), .mreq(mreq4),
      .mwrite(mwrite4), .maddr(maddr4), .mwdata(mwdata4), .mack_n(mack_n4),
      .mrdata(mrdata4), .grant_count(gc4), .busy_count(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for mreq, ack after dly cycles, return the channel whose cack_n pulsed.
   task automatic serve2(input int dly, input logic [255:0] rd, output int ch);
      int n;
      n = 0;
      while (!mreq2 && n < 20) begin
         step();
         n++;
      end
      check("serve2_mreq", 256'(mreq2), 256'(1));
      repeat (dly) step();
      mrdata2 = rd;
      mack_n2 = 1'b0;
      step();
      mack_n2 = 1'b1;
      ch = -1;
      for (int i = 0; i < 2; i++) if (!cack_n2[i]) ch = i;
   endtask

   task automatic serve4(input int dly, input logic [255:0] rd, output int ch);
      int n;
      n = 0;
      while (!mreq4 && n < 20) begin
         step();
         n++;
      end
      check("serve4_mreq", 256'(mreq4), 256'(1));
      repeat (dly) step();
      mrdata4 = rd;
      mack_n4 = 1'b0;
      step();
      mack_n4 = 1'b1;
      ch = -1;
      for (int i = 0; i < 4; i++) if (!cack_n4[i]) ch = i;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst2 = 1'b1; creq2 = '0; cwrite2 = '0; caddr2 = '0; cwdata2 = '0;
      mack_n2 = 1'b1; mrdata2 = '0;
      rst4 = 1'b1; creq4 = '0; cwrite4 = '0; caddr4 = '0; cwdata4 = '0;
      mack_n4 = 1'b1; mrdata4 = '0;
      repeat (2) step();

      // Reset state
      check("rst_mreq",   256'(mreq2),   256'(0));
      check("rst_cack",   256'(cack_n2), 256'(2'b11));
      check("rst_crdata", crdata2,       256'(0));
      check("rst_maddr",  256'(maddr2),  256'(0));
      check("rst_gc",     256'(gc2),     256'(0));
      check("rst_busy",   256'(busy2),   256'(0));
      check("rst4_cack",  256'(cack_n4), 256'(4'hF));
      rst2 = 1'b0;
      rst4 = 1'b0;
      step();

      // Single read on channel 0, ack 3 cycles after mreq
      caddr2[31:0] = 32'h1000;
      creq2 = 2'b01;
      step();
      check("rd_mreq",   256'(mreq2),  256'(1));
      check("rd_maddr",  256'(maddr2), 256'(32'h1000));
      check("rd_mwrite", 256'(mwrite2), 256'(0));
      repeat (3) step();
      check("rd_mreq_hold", 256'(mreq2), 256'(1));
      mrdata2 = {32{8'hA5}};
      mack_n2 = 1'b0;
      step();
      mack_n2 = 1'b1;
      creq2 = 2'b00;
      check("rd_cack",   256'(cack_n2), 256'(2'b10));
      check("rd_crdata", crdata2,       {32{8'hA5}});
      check("rd_gc0",    256'(gc2[31:0]), 256'(1));
      check("rd_busy",   256'(busy2),   256'(4));
      check("rd_mreq_drop", 256'(mreq2), 256'(0));
      step();
      check("rd_cack_one", 256'(cack_n2), 256'(2'b11));
      check("rd_busy_stop", 256'(busy2), 256'(4));

      // Contention from reset: both channels held, expect 0,1,0,1
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      caddr2 = {32'h3000, 32'h1000};
      creq2 = 2'b11;
      for (int t = 0; t < 4; t++) begin
         serve2(1, 256'(t + 192), gch);
         check("cont_order", 256'(gch), 256'(t % 2));
      end
      creq2 = 2'b00;
      check("cont_gc0", 256'(gc2[31:0]),  256'(2));
      check("cont_gc1", 256'(gc2[63:32]), 256'(2));
      check("cont_crdata", crdata2, 256'(195));
      step();

      // Write on channel 1: crdata must not change
      cwrite2 = 2'b10;
      caddr2[63:32] = 32'h2040;
      cwdata2[511:256] = {32{8'h55}};
      creq2 = 2'b10;
      step();
      check("wr_mreq",   256'(mreq2),   256'(1));
      check("wr_mwrite", 256'(mwrite2), 256'(1));
      check("wr_maddr",  256'(maddr2),  256'(32'h2040));
      check("wr_mwdata", mwdata2,       {32{8'h55}});
      serve2(2, {32{8'hEE}}, gch);
      creq2 = 2'b00;
      cwrite2 = 2'b00;
      check("wr_grant",  256'(gch), 256'(1));
      check("wr_crdata", crdata2,   256'(195));
      check("wr_gc1",    256'(gc2[63:32]), 256'(3));
      step();

      // Input stability: address change and creq drop during BUSY
      caddr2[31:0] = 32'h4000;
      creq2 = 2'b01;
      step();
      check("stab_maddr0", 256'(maddr2), 256'(32'h4000));
      caddr2[31:0] = 32'h9999;
      creq2 = 2'b00;
      step();
      check("stab_maddr1", 256'(maddr2), 256'(32'h4000));
      check("stab_mreq",   256'(mreq2),  256'(1));
      serve2(1, {32{8'h3C}}, gch);
      check("stab_grant",  256'(gch),    256'(0));
      check("stab_crdata", crdata2,      {32{8'h3C}});
      step();
      check("stab_cack_end", 256'(cack_n2), 256'(2'b11));
      step();
      check("stab_no_regrant", 256'(mreq2), 256'(0));

      // Reset two cycles into BUSY
      caddr2 = {32'h6000, 32'h5000};
      creq2 = 2'b01;
      step();
      step();
      step();
      check("mid_mreq_pre", 256'(mreq2), 256'(1));
      rst2 = 1'b1;
      #1;
      check("mid_mreq",  256'(mreq2),   256'(0));
      check("mid_cack",  256'(cack_n2), 256'(2'b11));
      check("mid_gc",    256'(gc2),     256'(0));
      check("mid_busy",  256'(busy2),   256'(0));
      step();
      rst2 = 1'b0;
      creq2 = 2'b11;
      step();
      check("mid_regrant_addr", 256'(maddr2), 256'(32'h5000));
      serve2(0, {32{8'h11}}, gch);
      creq2 = 2'b00;
      check("mid_regrant_ch", 256'(gch), 256'(0));
      check("mid_gc0", 256'(gc2[31:0]), 256'(1));

      // Counter wrap with CNT_WIDTH=4: 16 grants on channel 3
      caddr4 = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
      for (int t = 0; t < 16; t++) begin
         creq4 = 4'b1000;
         serve4(0, 256'(t), gch);
         creq4 = 4'b0000;
         if (t == 14) check("wrap_gc3_15", 256'(gc4[15:12]), 256'(15));
         step();
      end
      check("wrap_gc3",  256'(gc4[15:12]), 256'(0));
      check("wrap_gc_lo", 256'(gc4[11:0]), 256'(0));
      check("wrap_busy", 256'(busy4),      256'(0));

      // Rotation after channel 3 was last served: 0,1,2,3
      creq4 = 4'b1111;
      for (int t = 0; t < 4; t++) begin
         serve4(0, 256'(t), gch);
         check("rot_order", 256'(gch), 256'(t));
      end
      creq4 = 4'b0000;
      check("rot_gc",   256'(gc4),   256'(16'h1111));
      check("rot_busy", 256'(busy4), 256'(4));
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
